hazard_flush_controller: RTL and testbench
==========================================

// Module: hazard_flush_controller
// PURPOSE
//  Sequences the 5-stage pipeline: decides stall, bubble, flush and PC-redirect each cycle.
//  Keeps a shadow copy of the EX and MEM stage control state (dest, RegWrite, MemRead, branch, prediction).
//  Sits beside the ID-stage control decoder; consumes its decoded signals, drives the IF/ID and ID/EX pipeline registers and the PC mux.
//  Static prediction: backward branches taken (resolved in ID), forward branches not taken; all branches resolved in EX.
// PARAMETERS
//  REG_AW     5   register address width
//  STAT_W     32  width of statistics counters (used only with HAZARD_STATS_EN)
// PORTS
//  CLK            in   1       single clock, rising edge
//  Reset          in   1       synchronous, active-high
//  id_valid       in   1       ID holds a real instruction
//  id_rs          in   REG_AW  rs field
//  id_rt          in   REG_AW  rt field
//  id_uses_rs     in   1       instruction reads rs
//  id_uses_rt     in   1       instruction reads rt
//  id_dest        in   REG_AW  destination after RegDst mux (31 for jal)
//  id_regwrite    in   1       RegWrite from decoder
//  id_memread     in   1       MemRead from decoder
//  id_jump        in   1       j/jal (not jr)
//  id_jr          in   1       jr
//  id_branch      in   1       beq
//  id_backward    in   1       branch offset negative (prediction = taken)
//  ex_cond        in   1       ALU zero for the branch now in EX
//  pc_write       out  1       PC load enable
//  ifid_write     out  1       IF/ID load enable
//  ifid_flush     out  1       IF/ID cleared to nop on this edge
//  idex_bubble    out  1       ID/EX loaded with nop on this edge
//  redirect_sel   out  2       0 PC+4, 1 ID target (j/jal/predicted-taken beq), 2 EX correction, 3 jr rs
//  mispredict     out  1       EX branch outcome != prediction (one-cycle pulse)
// BEHAVIOUR
//  Shadow stages EXs, MEMs: {valid,dest,regwrite,memread,branch,pred}; each edge MEMs<=EXs, EXs<=ID (valid=0 if idex_bubble).
//  Outputs combinational from shadow state + ID inputs; priority high->low:
//   1 Reset=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, redirect_sel=0, mispredict=0; shadows cleared next edge.
//   2 Mispredict: EXs.valid&EXs.branch&(ex_cond!=EXs.pred) -> mispredict=1, redirect_sel=2, ifid_flush=1, idex_bubble=1, pc_write=1.
//   3 Load-use: EXs.valid&memread&regwrite&dest!=0 & (rs match&uses_rs | rt match&uses_rt) -> pc_write=0, ifid_write=0, idex_bubble=1. Exactly 1 cycle.
//   4 jr wait: id_jr and rs==EXs.dest (regwrite, dest!=0) or rs==MEMs.dest with MEMs.memread -> stall as in 3; up to 2 cycles.
//   5 Redirect in ID: id_jr -> sel=3; id_jump or (id_branch&id_backward) -> sel=1; ifid_flush=1, pc_write=1.
//   6 Otherwise: pc_write=1, ifid_write=1, flush/bubble=0, sel=0.
//  Predicted taken = id_branch&id_backward, latched into EXs.pred.
//  id_valid=0: no hazards/redirects from ID; dest 0 never creates a dependency.
//  Mispredict in same cycle as load-use/jr/jump in ID: mispredict wins; ID instruction discarded.
//  Reset mid-stall: stall drops immediately; no stale state after release.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds outputs stall_cnt, flush_cnt, mispred_cnt [STAT_W-1:0]; +1 on each cycle of
//   case 3/4, case 2/5, case 2 respectively; zeroed on Reset; saturate at all-ones.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package/header: redirect_sel encodings (RSEL_SEQ/ID/EX/JR), shadow-stage record field widths.
//  Sub-module hazard_shadow_pipe: EXs/MEMs registers with bubble insert and Reset clear; controller holds priority logic and counters.
// TESTING
//  lw $2,0($1); add $3,$2,$4 -> one cycle pc_write=0, idex_bubble=1; add issues next cycle; stall_cnt=1.
//  lw $0,0($1); add $3,$0,$4 -> no stall (dest 0).
//  addi $31,$0,8; jr $31 -> 1 stall cycle, then redirect_sel=3, ifid_flush=1.
//  backward beq predicted taken, ex_cond=0 in EX -> redirect_sel=1 in ID, then mispredict=1, redirect_sel=2, flush+bubble.
//  forward beq, ex_cond=1 -> mispredict=1, sel=2; same cycle j in ID ignored (sel stays 2).
//  Reset asserted during a load-use stall -> outputs per case 1 that cycle; after release no stall, sel=0.

Source files
------------

// File: rtl/hazard_flush_controller_pkg.sv
// -----------------------------------------------------------------------------
// hazard_flush_controller_pkg
//   Definitions shared by the pipeline hazard/flush controller and its shadow
//   stage registers:
//     - rsel_e      : PC mux select encodings (RSEL_SEQ/ID/EX/JR)
//     - ex_flags_t  : control record carried by the EX shadow stage
//     - mem_flags_t : control record carried by the MEM shadow stage
//   The destination register field is kept outside the records so its width
//   can follow the REG_AW parameter of the instantiating module.
// -----------------------------------------------------------------------------
package hazard_flush_controller_pkg;

  localparam int RSEL_W = 2;

  typedef enum logic [RSEL_W-1:0] {
    RSEL_SEQ = 2'd0,  // PC + 4
    RSEL_ID  = 2'd1,  // target computed in ID (j/jal/predicted-taken beq)
    RSEL_EX  = 2'd2,  // correction after a branch mispredict in EX
    RSEL_JR  = 2'd3   // jr through rs
  } rsel_e;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
    logic branch;
    logic pred;      // 1 = predicted taken
  } ex_flags_t;

  // Branches are resolved in EX, so the MEM copy only keeps what a later
  // dependency check can still use.
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
  } mem_flags_t;

endpackage

// File: rtl/hazard_flush_controller_shadow_pipe.sv
// -----------------------------------------------------------------------------
// hazard_shadow_pipe
//   Shadow copy of the EX and MEM stage control state. Every edge the MEM copy
//   takes the EX copy and the EX copy takes the ID-stage decode; a bubble or
//   an invalid ID slot loads an invalid EX entry. Reset clears both stages.
// Ports:
//   CLK, Reset            clock, synchronous active-high reset
//   bubble                ID/EX is loaded with a nop on this edge
//   id_valid/id_dest/...  decode of the instruction in ID
//   id_pred               static prediction (taken) for a branch in ID
//   ex_flags, ex_dest     EX shadow stage
//   mem_flags, mem_dest   MEM shadow stage
// -----------------------------------------------------------------------------
module hazard_shadow_pipe
  import hazard_flush_controller_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              bubble,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_branch,
  input  logic              id_pred,
  output ex_flags_t         ex_flags,
  output logic [REG_AW-1:0] ex_dest,
  output mem_flags_t        mem_flags,
  output logic [REG_AW-1:0] mem_dest
);

  ex_flags_t         ex_flags_d, ex_flags_q;
  mem_flags_t        mem_flags_d, mem_flags_q;
  logic [REG_AW-1:0] ex_dest_d, ex_dest_q;
  logic [REG_AW-1:0] mem_dest_d, mem_dest_q;

  always_comb begin
    ex_flags_d.valid    = id_valid & ~bubble;
    ex_flags_d.regwrite = id_regwrite;
    ex_flags_d.memread  = id_memread;
    ex_flags_d.branch   = id_branch;
    ex_flags_d.pred     = id_pred;
    ex_dest_d           = id_dest;

    mem_flags_d.valid    = ex_flags_q.valid;
    mem_flags_d.regwrite = ex_flags_q.regwrite;
    mem_flags_d.memread  = ex_flags_q.memread;
    mem_dest_d           = ex_dest_q;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      ex_flags_q  <= '0;
      ex_dest_q   <= '0;
      mem_flags_q <= '0;
      mem_dest_q  <= '0;
    end else begin
      ex_flags_q  <= ex_flags_d;
      ex_dest_q   <= ex_dest_d;
      mem_flags_q <= mem_flags_d;
      mem_dest_q  <= mem_dest_d;
    end
  end

  assign ex_flags  = ex_flags_q;
  assign ex_dest   = ex_dest_q;
  assign mem_flags = mem_flags_q;
  assign mem_dest  = mem_dest_q;

endmodule

// File: rtl/hazard_flush_controller.sv
// -----------------------------------------------------------------------------
// hazard_flush_controller
//   Decides stall, bubble, flush and PC redirect for a 5-stage pipeline each
//   cycle. Static prediction: backward beq predicted taken (redirected in ID),
//   forward beq not taken; every branch is resolved in EX against ex_cond.
//   Priority (high to low): Reset, EX mispredict, load-use stall, jr wait
//   stall, ID redirect (jr / j / predicted-taken beq), sequential.
// Ports:
//   CLK, Reset                  clock, synchronous active-high reset
//   id_*                        decode of the instruction in ID
//   ex_cond                     branch outcome (ALU zero) for the EX branch
//   pc_write, ifid_write        PC / IF/ID load enables
//   ifid_flush, idex_bubble     IF/ID cleared / ID/EX loaded with nop
//   redirect_sel                PC mux select (rsel_e)
//   mispredict                  EX outcome differs from prediction
//   stall_cnt, flush_cnt,       saturating statistics counters, present
//   mispred_cnt                 only when HAZARD_STATS_EN is defined
// -----------------------------------------------------------------------------
module hazard_flush_controller
  import hazard_flush_controller_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int STAT_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_jump,
  input  logic              id_jr,
  input  logic              id_branch,
  input  logic              id_backward,
  input  logic              ex_cond,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        redirect_sel,
  output logic              mispredict
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt,
  output logic [STAT_W-1:0] mispred_cnt
`endif
);

  if (REG_AW < 1 || STAT_W < 1) begin : g_bad_param
    $error("hazard_flush_controller: REG_AW and STAT_W must be positive");
  end

  ex_flags_t         ex_flags;
  mem_flags_t        mem_flags;
  logic [REG_AW-1:0] ex_dest, mem_dest;

  hazard_shadow_pipe #(.REG_AW(REG_AW)) u_shadow (
    .CLK         (CLK),
    .Reset       (Reset),
    .bubble      (idex_bubble),
    .id_valid    (id_valid),
    .id_dest     (id_dest),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_branch   (id_branch),
    .id_pred     (id_branch & id_backward),
    .ex_flags    (ex_flags),
    .ex_dest     (ex_dest),
    .mem_flags   (mem_flags),
    .mem_dest    (mem_dest)
  );

  logic mispred_hit, ex_load, load_use_hit, jr_ex_hit, jr_mem_hit, jr_wait_hit;
  logic stall_evt, flush_evt;
  rsel_e sel;

  assign mispred_hit  = ex_flags.valid & ex_flags.branch & (ex_cond != ex_flags.pred);
  // A load in EX with a non-zero destination is the only load-use source.
  assign ex_load      = ex_flags.valid & ex_flags.memread & ex_flags.regwrite & (ex_dest != '0);
  assign load_use_hit = id_valid & ex_load &
                        ((id_uses_rs & (id_rs == ex_dest)) | (id_uses_rt & (id_rt == ex_dest)));
  // jr reads rs in ID, so it waits for any producer in EX and for a load in MEM.
  assign jr_ex_hit    = ex_flags.valid & ex_flags.regwrite & (ex_dest != '0) & (id_rs == ex_dest);
  assign jr_mem_hit   = mem_flags.valid & mem_flags.memread & mem_flags.regwrite &
                        (mem_dest != '0) & (id_rs == mem_dest);
  assign jr_wait_hit  = id_valid & id_jr & (jr_ex_hit | jr_mem_hit);

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    sel         = RSEL_SEQ;
    mispredict  = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;
    if (Reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mispred_hit) begin
      // Whatever sits in ID is on the wrong path and is discarded.
      mispredict  = 1'b1;
      sel         = RSEL_EX;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_evt   = 1'b1;
    end else if (load_use_hit || jr_wait_hit) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      stall_evt   = 1'b1;
    end else if (id_valid && id_jr) begin
      sel        = RSEL_JR;
      ifid_flush = 1'b1;
      flush_evt  = 1'b1;
    end else if (id_valid && (id_jump || (id_branch && id_backward))) begin
      sel        = RSEL_ID;
      ifid_flush = 1'b1;
      flush_evt  = 1'b1;
    end
  end

  assign redirect_sel = sel;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [STAT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic [STAT_W-1:0] mispred_cnt_d, mispred_cnt_q;

  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (stall_evt && (stall_cnt_q != '1))     stall_cnt_d   = stall_cnt_q + 1'b1;
    if (flush_evt && (flush_cnt_q != '1))     flush_cnt_d   = flush_cnt_q + 1'b1;
    if (mispredict && (mispred_cnt_q != '1))  mispred_cnt_d = mispred_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      mispred_cnt_q <= '0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = stall_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_hazard_flush_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_flush_controller
//   Directed pipeline scenarios followed by random decode traffic, checked
//   every cycle against a reference model that tracks the in-flight
//   instructions as a two-entry queue (EX at index 0, MEM at index 1).
// -----------------------------------------------------------------------------
module tb_hazard_flush_controller;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic Reset;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- DUT ----------------
  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic       j;
    logic       jr;
    logic       br;
    logic       bw;
  } id_t;

  id_t  id;
  logic ex_cond;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, mispredict;
  logic [1:0] redirect_sel;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt, mispred_cnt;
`endif

  hazard_flush_controller #(.REG_AW(5), .STAT_W(32)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .id_valid     (id.valid),
    .id_rs        (id.rs),
    .id_rt        (id.rt),
    .id_uses_rs   (id.urs),
    .id_uses_rt   (id.urt),
    .id_dest      (id.dest),
    .id_regwrite  (id.rw),
    .id_memread   (id.mr),
    .id_jump      (id.j),
    .id_jr        (id.jr),
    .id_branch    (id.br),
    .id_backward  (id.bw),
    .ex_cond      (ex_cond),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .redirect_sel (redirect_sel),
    .mispredict   (mispredict)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .mispred_cnt  (mispred_cnt)
`endif
  );

  // ---------------- instruction builders ----------------
  function automatic id_t i_nop();
    id_t x = '0;
    return x;
  endfunction

  function automatic id_t i_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    id_t x = '0;
    x.valid = 1'b1; x.rs = rs; x.rt = rt; x.urs = 1'b1; x.urt = 1'b1; x.dest = rd; x.rw = 1'b1;
    return x;
  endfunction

  function automatic id_t i_addi(input logic [4:0] rt, input logic [4:0] rs);
    id_t x = '0;
    x.valid = 1'b1; x.rs = rs; x.rt = rt; x.urs = 1'b1; x.dest = rt; x.rw = 1'b1;
    return x;
  endfunction

  function automatic id_t i_lw(input logic [4:0] rt, input logic [4:0] base);
    id_t x = i_addi(rt, base);
    x.mr = 1'b1;
    return x;
  endfunction

  function automatic id_t i_jr(input logic [4:0] rs);
    id_t x = '0;
    x.valid = 1'b1; x.rs = rs; x.urs = 1'b1; x.jr = 1'b1;
    return x;
  endfunction

  function automatic id_t i_j();
    id_t x = '0;
    x.valid = 1'b1; x.j = 1'b1;
    return x;
  endfunction

  function automatic id_t i_beq(input logic [4:0] rs, input logic [4:0] rt, input logic bw);
    id_t x = '0;
    x.valid = 1'b1; x.rs = rs; x.rt = rt; x.urs = 1'b1; x.urt = 1'b1; x.br = 1'b1; x.bw = bw;
    return x;
  endfunction

  // ---------------- reference model ----------------
  // One record per instruction that has left ID: what it will write, whether
  // it is a load, and, for branches, the direction it was predicted.
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic       br;
    logic       pred;
  } stg_t;

  stg_t pipe_q[$];
  int   m_stall, m_flush, m_mispred;

  // Expected vector: {pc_write, ifid_write, ifid_flush, idex_bubble, sel[1:0], mispredict}
  localparam logic [6:0] E_RESET = {1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0};
  localparam logic [6:0] E_MISP  = {1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1};
  localparam logic [6:0] E_STALL = {1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
  localparam logic [6:0] E_JR    = {1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0};
  localparam logic [6:0] E_IDRD  = {1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0};
  localparam logic [6:0] E_SEQ   = {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};

  function automatic logic [6:0] model_eval();
    stg_t ex  = pipe_q[0];
    stg_t mem = pipe_q[1];
    logic ld_hit, jr_hit;
    if (Reset) return E_RESET;
    if (ex.valid && ex.br && (ex_cond != ex.pred)) return E_MISP;
    ld_hit = id.valid && ex.valid && ex.mr && ex.rw && (ex.dest != 0) &&
             ((id.urs && id.rs == ex.dest) || (id.urt && id.rt == ex.dest));
    jr_hit = id.valid && id.jr &&
             ((ex.valid && ex.rw && ex.dest != 0 && id.rs == ex.dest) ||
              (mem.valid && mem.mr && mem.rw && mem.dest != 0 && id.rs == mem.dest));
    if (ld_hit || jr_hit) return E_STALL;
    if (id.valid && id.jr) return E_JR;
    if (id.valid && (id.j || (id.br && id.bw))) return E_IDRD;
    return E_SEQ;
  endfunction

  task automatic model_advance(input logic [6:0] e);
    stg_t n;
    if (Reset) begin
      pipe_q = {stg_t'(0), stg_t'(0)};
      m_stall = 0; m_flush = 0; m_mispred = 0;
    end else begin
      n.valid = id.valid && !e[3];
      n.dest  = id.dest;
      n.rw    = id.rw;
      n.mr    = id.mr;
      n.br    = id.br;
      n.pred  = id.br && id.bw;
      pipe_q.push_front(n);
      void'(pipe_q.pop_back());
      if (!e[6]) m_stall++;
      if (e[4])  m_flush++;
      if (e[0])  m_mispred++;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];
  int n_cmp, n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Inputs are already applied; check outputs mid-cycle, then let the edge
  // move both the DUT and the model.
  task automatic tick(input string name);
    logic [6:0] e;
    @(negedge CLK);
    exp_q.push_back(model_eval());
    e = exp_q.pop_front();
    check({name, ".pc_write"},     {31'd0, pc_write},     {31'd0, e[6]});
    check({name, ".ifid_write"},   {31'd0, ifid_write},   {31'd0, e[5]});
    check({name, ".ifid_flush"},   {31'd0, ifid_flush},   {31'd0, e[4]});
    check({name, ".idex_bubble"},  {31'd0, idex_bubble},  {31'd0, e[3]});
    check({name, ".redirect_sel"}, {30'd0, redirect_sel}, {30'd0, e[2:1]});
    check({name, ".mispredict"},   {31'd0, mispredict},   {31'd0, e[0]});
    @(posedge CLK);
    model_advance(e);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input id_t x, input logic cond, input logic rst);
    id      = x;
    ex_cond = cond;
    Reset   = rst;
  endtask

  function automatic id_t rand_instr();
    id_t x = '0;
    logic [4:0] d;
    d = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
    case ($urandom_range(0, 6))
      0: x = i_nop();
      1: x = i_add(d, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      2: x = i_lw(d, 5'($urandom_range(0, 3)));
      3: x = i_jr(($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 3)));
      4: x = i_j();
      5: x = i_beq(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      default: x = i_addi(d, 5'($urandom_range(0, 3)));
    endcase
    if ($urandom_range(0, 9) == 0) x.valid = 1'b0;
    return x;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_fail = 0;
    m_stall = 0; m_flush = 0; m_mispred = 0;
    pipe_q = {stg_t'(0), stg_t'(0)};
    drive(i_nop(), 1'b0, 1'b1);
    #1;
    tick("reset0");
    drive(i_lw(5'd2, 5'd1), 1'b0, 1'b1);
    tick("reset1");

    // lw $2,0($1); add $3,$2,$4 -> one stall cycle, then add issues
    drive(i_lw(5'd2, 5'd1), 1'b0, 1'b0);       tick("lu_lw");
    drive(i_add(5'd3, 5'd2, 5'd4), 1'b0, 1'b0); tick("lu_stall");
    tick("lu_issue");
    drive(i_nop(), 1'b0, 1'b0);                 tick("lu_drain");

    // lw $0; add $3,$0,$4 -> no stall
    drive(i_lw(5'd0, 5'd1), 1'b0, 1'b0);       tick("z_lw");
    drive(i_add(5'd3, 5'd0, 5'd4), 1'b0, 1'b0); tick("z_add");

    // addi $31,$0,8; jr $31 -> one stall, then jr redirect
    drive(i_addi(5'd31, 5'd0), 1'b0, 1'b0);    tick("jr_addi");
    drive(i_jr(5'd31), 1'b0, 1'b0);            tick("jr_stall");
    tick("jr_go");
    drive(i_nop(), 1'b0, 1'b0);                tick("jr_drain");

    // lw $5; jr $5 -> two stall cycles
    drive(i_lw(5'd5, 5'd1), 1'b0, 1'b0);       tick("jrl_lw");
    drive(i_jr(5'd5), 1'b0, 1'b0);             tick("jrl_stall1");
    tick("jrl_stall2");
    tick("jrl_go");
    drive(i_nop(), 1'b0, 1'b0);                tick("jrl_drain");

    // backward beq predicted taken, not taken in EX
    drive(i_beq(5'd1, 5'd2, 1'b1), 1'b0, 1'b0); tick("bb_id");
    drive(i_add(5'd6, 5'd1, 5'd1), 1'b0, 1'b0); tick("bb_misp");
    drive(i_nop(), 1'b0, 1'b0);                 tick("bb_drain");

    // forward beq taken in EX; j in ID at the same time is discarded
    drive(i_beq(5'd1, 5'd2, 1'b0), 1'b0, 1'b0); tick("fb_id");
    drive(i_j(), 1'b1, 1'b0);                   tick("fb_misp");
    drive(i_nop(), 1'b0, 1'b0);                 tick("fb_drain");

    // Reset during a load-use stall
    drive(i_lw(5'd2, 5'd1), 1'b0, 1'b0);       tick("rs_lw");
    drive(i_add(5'd3, 5'd2, 5'd4), 1'b0, 1'b1); tick("rs_reset");
    drive(i_add(5'd3, 5'd2, 5'd4), 1'b0, 1'b0); tick("rs_after");

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive(rand_instr(), 1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0));
      tick("rand");
    end

`ifdef HAZARD_STATS_EN
    @(negedge CLK);
    check("stall_cnt",   stall_cnt,   32'(m_stall));
    check("flush_cnt",   flush_cnt,   32'(m_flush));
    check("mispred_cnt", mispred_cnt, 32'(m_mispred));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
